// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse trainer blocks.
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_LTR = 3'd2,
        S_ANSWER   = 3'd3,
        S_SHOW     = 3'd4,
        S_DONE     = 3'd5
    } session_state_e;

    // Decoder symbol timing in 100 Hz ticks.
    localparam int DOT_TIME  = 10;
    localparam int DASH_TIME = 30;
    localparam int GAP_TIME  = 10;
    localparam int CHAR_TIME = 30;

    // Session defaults.
    localparam int DEF_ROUNDS         = 10;
    localparam int DEF_ANSWER_TIMEOUT = 1000;
    localparam int DEF_RESULT_HOLD    = 100;
    localparam int DEF_PASS_SCORE     = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morse_session_ctrl_if.sv
// Letter generator / decoder / result bus around the session controller.
interface morse_session_ctrl_if #(
    parameter int CW = 4
);
    logic          letter_req_o;
    logic          letter_ready_i;
    logic          dec_arm_o;
    logic          dec_done_i;
    logic          dec_correct_i;
    logic          result_valid_o;
    logic          result_ok_o;
    logic          timeout_o;
    logic [CW-1:0] round_o;
    logic [CW-1:0] score_o;
    logic          session_done_o;
    logic          pass_o;

    // Controller side.
    modport slave (
        input  letter_ready_i, dec_done_i, dec_correct_i,
        output letter_req_o, dec_arm_o, result_valid_o, result_ok_o, timeout_o,
               round_o, score_o, session_done_o, pass_o
    );

    // Environment side (letter block, decoder, display).
    modport master (
        output letter_ready_i, dec_done_i, dec_correct_i,
        input  letter_req_o, dec_arm_o, result_valid_o, result_ok_o, timeout_o,
               round_o, score_o, session_done_o, pass_o
    );
endinterface

// File: rtl/morse_tick_timer.sv
// Load/enable up-counter with a terminal-count hit flag.
module morse_tick_timer #(
    parameter int TW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [TW-1:0] tc_i,
    output logic          hit_o
);
    logic [TW-1:0] count_q, count_d;

    // Load restarts the count at zero; enable advances it.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + TW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign hit_o = (count_q == tc_i);
endmodule

// File: rtl/morse_session_ctrl.sv
// Round sequencer for the Morse trainer: letter request, answer window,
// result display and score keeping.
//
// state      | meaning
// S_IDLE     | waiting for a start rising edge, round/score held
// S_REQ      | one-cycle letter request
// S_WAIT_LTR | waiting for the letter generator
// S_ANSWER   | decoder armed, answer timer running
// S_SHOW     | showing round result for RESULT_HOLD cycles
// S_DONE     | session complete, waiting for start to drop
module morse_session_ctrl
    import morse_pkg::*;
#(
    parameter int ROUNDS         = DEF_ROUNDS,
    parameter int ANSWER_TIMEOUT = DEF_ANSWER_TIMEOUT,
    parameter int RESULT_HOLD    = DEF_RESULT_HOLD,
    parameter int PASS_SCORE     = DEF_PASS_SCORE
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    morse_session_ctrl_if.slave bus
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam int TW = $clog2(max_int(ANSWER_TIMEOUT, RESULT_HOLD));

    localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);
    localparam logic [CW-1:0] PASS_C   = CW'(PASS_SCORE);
    localparam logic [TW-1:0] ANS_TC   = TW'(ANSWER_TIMEOUT - 1);
    localparam logic [TW-1:0] SHOW_TC  = TW'(RESULT_HOLD - 1);

    session_state_e state_q, state_d;
    logic [CW-1:0]  round_q, round_d, score_q, score_d;
    logic           ok_q, ok_d, to_q, to_d;
    logic           start_q, armed_q, start_rise;
    logic           tmr_load, tmr_en, tmr_hit;
    logic [TW-1:0]  tmr_tc;

    // armed_q keeps a start level held through reset from counting as an
    // edge: a session needs start_i to be seen low at least once first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            start_q <= start_i;
            if (!start_i) armed_q <= 1'b1;
        end
    end

    assign start_rise = start_i && !start_q && armed_q;

    // Next state, score/round and result-flag updates.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        score_d = score_q;
        ok_d    = ok_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_REQ;
                    round_d = '0;
                    score_d = '0;
                end
            end
            S_REQ: begin
                state_d = start_i ? S_WAIT_LTR : S_IDLE;
            end
            S_WAIT_LTR: begin
                if (!start_i)                 state_d = S_IDLE;
                else if (bus.letter_ready_i)  state_d = S_ANSWER;
            end
            S_ANSWER: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (bus.dec_done_i) begin
                    state_d = S_SHOW;
                    ok_d    = bus.dec_correct_i;
                    to_d    = 1'b0;
                    if (bus.dec_correct_i && score_q != ROUNDS_C) score_d = score_q + CW'(1);
                end else if (tmr_hit) begin
                    state_d = S_SHOW;
                    ok_d    = 1'b0;
                    to_d    = 1'b1;
                end
            end
            S_SHOW: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (tmr_hit) begin
                    if (round_q != ROUNDS_C) round_d = round_q + CW'(1);
                    state_d = (round_d == ROUNDS_C) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                if (!start_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
            score_q <= '0;
            ok_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            score_q <= score_d;
            ok_q    <= ok_d;
            to_q    <= to_d;
        end
    end

    // One timer covers both the answer window and the result display;
    // every state change restarts it at zero.
    assign tmr_load = (state_d != state_q);
    assign tmr_en   = (state_q == S_ANSWER) || (state_q == S_SHOW);
    assign tmr_tc   = (state_q == S_ANSWER) ? ANS_TC : SHOW_TC;

    morse_tick_timer #(.TW(TW)) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_i   (tmr_tc),
        .hit_o  (tmr_hit)
    );

    assign bus.letter_req_o   = (state_q == S_REQ);
    assign bus.dec_arm_o      = (state_q == S_ANSWER);
    assign bus.result_valid_o = (state_q == S_SHOW);
    assign bus.result_ok_o    = (state_q == S_SHOW) && ok_q;
    assign bus.timeout_o      = (state_q == S_SHOW) && to_q;
    assign bus.round_o        = round_q;
    assign bus.score_o        = score_q;
    assign bus.session_done_o = (state_q == S_DONE);
    assign bus.pass_o         = (state_q == S_DONE) && (score_q >= PASS_C);
endmodule

// File: tb/tb_morse_session_ctrl.sv
// Bench for morse_session_ctrl: cycle-level reference model with a per-cycle
// compare, directed scenarios with literal expectations, then random traffic.
module tb_morse_session_ctrl;
    localparam int ROUNDS = 3;
    localparam int AT     = 8;
    localparam int RH     = 4;
    localparam int PASS   = 2;
    localparam int CW     = $clog2(ROUNDS + 1);

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_ANS = 3, PH_SHOW = 4, PH_DONE = 5;

    logic clk = 1'b0;
    logic rst;
    logic start;

    morse_session_ctrl_if #(.CW(CW)) bus ();

    morse_session_ctrl #(
        .ROUNDS(ROUNDS), .ANSWER_TIMEOUT(AT), .RESULT_HOLD(RH), .PASS_SCORE(PASS)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int m_ph, m_cnt, m_round, m_score;
    bit m_ok, m_to, m_prev, m_seen_low;
    int n_ph, n_round, n_score;
    bit n_ok, n_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= PH_IDLE; m_cnt <= 0; m_round <= 0; m_score <= 0;
            m_ok <= 0; m_to <= 0; m_prev <= 0; m_seen_low <= 0;
        end else begin
            n_ph = m_ph; n_round = m_round; n_score = m_score; n_ok = m_ok; n_to = m_to;
            if (m_ph == PH_IDLE) begin
                if (start && !m_prev && m_seen_low) begin
                    n_ph = PH_REQ; n_round = 0; n_score = 0;
                end
            end else if (!start) begin
                if (m_ph != PH_DONE || !start) n_ph = PH_IDLE;
            end else begin
                case (m_ph)
                    PH_REQ:  n_ph = PH_WAIT;
                    PH_WAIT: if (bus.letter_ready_i) n_ph = PH_ANS;
                    PH_ANS: begin
                        // m_cnt+1 = number of answer cycles including this one
                        if (bus.dec_done_i) begin
                            n_ph = PH_SHOW; n_ok = bus.dec_correct_i; n_to = 0;
                            if (bus.dec_correct_i && m_score < ROUNDS) n_score = m_score + 1;
                        end else if (m_cnt + 1 == AT) begin
                            n_ph = PH_SHOW; n_ok = 0; n_to = 1;
                        end
                    end
                    PH_SHOW: if (m_cnt + 1 == RH) begin
                        n_round = (m_round < ROUNDS) ? m_round + 1 : m_round;
                        n_ph = (n_round == ROUNDS) ? PH_DONE : PH_REQ;
                    end
                    default: ;
                endcase
            end
            m_cnt   <= (n_ph == m_ph) ? m_cnt + 1 : 0;
            m_ph    <= n_ph;
            m_round <= n_round;
            m_score <= n_score;
            m_ok    <= n_ok;
            m_to    <= n_to;
            m_prev  <= start;
            if (!start) m_seen_low <= 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [10:0] exp_v, act_v;
    int req_pulses = 0;
    int arm_len = 0;
    int arm_last_len = 0;

    always @(negedge clk) begin
        exp_v = {m_ph == PH_REQ, m_ph == PH_ANS, m_ph == PH_SHOW,
                 (m_ph == PH_SHOW) && m_ok, (m_ph == PH_SHOW) && m_to,
                 CW'(m_round), CW'(m_score),
                 m_ph == PH_DONE, (m_ph == PH_DONE) && (m_score >= PASS)};
        act_v = {bus.letter_req_o, bus.dec_arm_o, bus.result_valid_o,
                 bus.result_ok_o, bus.timeout_o, bus.round_o, bus.score_o,
                 bus.session_done_o, bus.pass_o};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_compare t=%0t dut=%b model=%b", $time, act_v, exp_v);
        end
        if (bus.letter_req_o) req_pulses <= req_pulses + 1;
        if (bus.dec_arm_o) arm_len <= arm_len + 1;
        else if (arm_len != 0) begin
            arm_last_len <= arm_len;
            arm_len <= 0;
        end
    end

    // ---------------- decoder / responder ----------------
    int resp_mode = 0;      // 0 quiet, 1 answer at resp_at-th armed cycle, 2 random
    int resp_at = 5;
    bit resp_correct = 1'b1;
    int arm_run = 0;

    always @(negedge clk) begin
        if (bus.dec_arm_o) arm_run = arm_run + 1;
        else arm_run = 0;
        bus.dec_done_i = 1'b0;
        bus.dec_correct_i = 1'b0;
        case (resp_mode)
            1: if (resp_at != 0 && arm_run == resp_at) begin
                bus.dec_done_i = 1'b1;
                bus.dec_correct_i = resp_correct;
            end
            2: begin
                bus.dec_done_i = ($urandom_range(0, 5) == 0);
                bus.dec_correct_i = $urandom_range(0, 1) == 1;
            end
            default: ;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sig(input int sel);
        case (sel)
            0: return int'(bus.letter_req_o);
            1: return int'(bus.dec_arm_o);
            2: return int'(bus.result_valid_o);
            3: return int'(bus.round_o);
            4: return int'(bus.session_done_o);
            default: return 0;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int val, input int budget, input string name);
        int n = 0;
        while (sig(sel) != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) != val) begin
            checks++;
            failures++;
            $display("FAIL %s: timed out after %0d cycles, got %0d expected %0d",
                     name, budget, sig(sel), val);
        end
    endtask

    int req0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.letter_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({bus.letter_req_o, bus.dec_arm_o, bus.result_valid_o,
            bus.result_ok_o, bus.timeout_o, bus.round_o, bus.score_o,
            bus.session_done_o, bus.pass_o}), 0);
        rst = 1'b0;
        bus.letter_ready_i = 1'b1;
        repeat (2) @(negedge clk);

        // A: three correct answers, latency pins
        resp_mode = 1; resp_at = 5; resp_correct = 1'b1;
        req0 = req_pulses;
        start = 1'b1;
        @(negedge clk); chk("start_latency_req", int'(bus.letter_req_o), 1);
        @(negedge clk); chk("wait_ltr_req_low", int'(bus.letter_req_o), 0);
        chk("wait_ltr_arm_low", int'(bus.dec_arm_o), 0);
        @(negedge clk); chk("arm_latency", int'(bus.dec_arm_o), 1);
        wait_until(4, 1, 120, "wait_done_A");
        chk("A_score", int'(bus.score_o), 3);
        chk("A_round", int'(bus.round_o), 3);
        chk("A_pass", int'(bus.pass_o), 1);
        @(negedge clk);
        chk("A_req_pulses", req_pulses - req0, 3);

        // held start after DONE must not re-trigger
        req0 = req_pulses;
        repeat (20) @(negedge clk);
        chk("held_start_no_req", req_pulses - req0, 0);
        chk("held_start_done", int'(bus.session_done_o), 1);
        start = 1'b0;
        @(negedge clk);
        chk("done_to_idle", int'(bus.session_done_o), 0);
        chk("idle_round_hold", int'(bus.round_o), 3);

        // B: timeout, last-cycle correct answer, wrong answer
        resp_at = 0;
        start = 1'b1;
        @(negedge clk);
        chk("B_req", int'(bus.letter_req_o), 1);
        chk("B_round_clear", int'(bus.round_o), 0);
        chk("B_score_clear", int'(bus.score_o), 0);
        wait_until(2, 1, 40, "wait_show_B1");
        chk("B1_timeout", int'(bus.timeout_o), 1);
        chk("B1_ok", int'(bus.result_ok_o), 0);
        chk("B1_score", int'(bus.score_o), 0);
        @(negedge clk);
        chk("B1_arm_len", arm_last_len, AT);
        resp_at = AT; resp_correct = 1'b1;
        wait_until(2, 0, 20, "wait_show_end_B1");
        wait_until(2, 1, 40, "wait_show_B2");
        chk("B2_ok", int'(bus.result_ok_o), 1);
        chk("B2_timeout", int'(bus.timeout_o), 0);
        chk("B2_score", int'(bus.score_o), 1);
        @(negedge clk);
        chk("B2_arm_len", arm_last_len, AT);
        resp_at = 3; resp_correct = 1'b0;
        wait_until(2, 0, 20, "wait_show_end_B2");
        wait_until(2, 1, 40, "wait_show_B3");
        chk("B3_ok", int'(bus.result_ok_o), 0);
        chk("B3_timeout", int'(bus.timeout_o), 0);
        wait_until(4, 1, 40, "wait_done_B");
        chk("B_score", int'(bus.score_o), 1);
        chk("B_pass", int'(bus.pass_o), 0);

        // C: abort mid-answer in round 2
        start = 1'b0;
        @(negedge clk);
        resp_at = 5; resp_correct = 1'b1;
        start = 1'b1;
        wait_until(3, 1, 40, "wait_round1_C");
        wait_until(1, 1, 20, "wait_arm_C");
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("C_arm_drop", int'(bus.dec_arm_o), 0);
        chk("C_round_frozen", int'(bus.round_o), 1);
        chk("C_score_frozen", int'(bus.score_o), 1);
        repeat (3) @(negedge clk);
        chk("C_round_still", int'(bus.round_o), 1);
        start = 1'b1;
        @(negedge clk);
        chk("C_restart_req", int'(bus.letter_req_o), 1);
        chk("C_restart_round", int'(bus.round_o), 0);

        // D: async reset during SHOW
        wait_until(2, 1, 40, "wait_show_D");
        #2 rst = 1'b1;
        #1 chk("D_async_reset", int'({bus.letter_req_o, bus.dec_arm_o, bus.result_valid_o,
            bus.result_ok_o, bus.timeout_o, bus.round_o, bus.score_o,
            bus.session_done_o, bus.pass_o}), 0);
        @(negedge clk);
        rst = 1'b0;
        req0 = req_pulses;
        repeat (10) @(negedge clk);
        @(negedge clk);
        chk("D_no_start_after_reset", req_pulses - req0, 0);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("D_toggle_starts", int'(bus.letter_req_o), 1);

        // E: random traffic against the model
        resp_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) start = ~start;
            bus.letter_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/morse_session_ctrl.md
# morse_session_ctrl

Session controller for the Morse trainer. It sequences a fixed number of quiz rounds: it asks the seven-segment letter generator for a new letter, arms the Morse input decoder, and waits for the decoder's verdict or an answer timeout. It then shows the per-round result and accumulates the score. It sits between the user start input, the letter/display block and the decoder, and owns all round-level sequencing.

## Interface
Parameters:
- ROUNDS, 10: rounds per session (≥1)
- ANSWER_TIMEOUT, 1000: cycles allowed per answer (10 s at 100 Hz, ≥2)
- RESULT_HOLD, 100: cycles the round result is shown (≥1)
- PASS_SCORE, 7: minimum score for pass_o (≤ROUNDS)

Ports:
- clk_i  in  1  clock; one clock domain, everything on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  user start level; rising edge starts a session, low aborts it
- letter_req_o  out  1  one-cycle pulse requesting a new random letter
- letter_ready_i  in  1  letter generator has a letter displayed
- dec_arm_o  out  1  decoder enable; the decoder clears its state while low
- dec_done_i  in  1  one-cycle pulse: decoder finished a character
- dec_correct_i  in  1  verdict, valid only with dec_done_i
- result_valid_o  out  1  high during result display
- result_ok_o  out  1  last round correct; valid with result_valid_o
- timeout_o  out  1  last round timed out; valid with result_valid_o
- round_o  out  CW  completed rounds, CW = $clog2(ROUNDS+1)
- score_o  out  CW  correct rounds
- session_done_o  out  1  session finished normally
- pass_o  out  1  score_o ≥ PASS_SCORE; valid with session_done_o

## Operation
States: IDLE, REQ, WAIT_LTR, ANSWER, SHOW, DONE.

- **IDLE:** all outputs low except round_o/score_o, which hold their last values.
  - A start_i rising edge (start_i high, registered previous value low) goes to REQ.
  - On that transition round_o and score_o clear to 0.
- **REQ:** lasts exactly one cycle with letter_req_o=1, then goes to WAIT_LTR.
- **WAIT_LTR:** waits for letter_ready_i=1, which is sampled from the first WAIT_LTR cycle onward, then goes to ANSWER.
- **ANSWER:** dec_arm_o=1 and the timer restarts at 0 on entry.
  - dec_done_i=1: go to SHOW; result_ok_o ← dec_correct_i, timeout_o ← 0; score_o increments if correct.
  - Timer reaches ANSWER_TIMEOUT−1 with no done: go to SHOW; result_ok_o ← 0, timeout_o ← 1.
  - If done and timeout occur in the same cycle, done wins.
- **SHOW:** dec_arm_o=0 and result_valid_o=1 for exactly RESULT_HOLD cycles. On exit round_o increments.
  - If the new round_o == ROUNDS, go to DONE; otherwise go to REQ.
- **DONE:** session_done_o=1 and pass_o=(score_o ≥ PASS_SCORE). Stays in DONE while start_i=1, and goes to IDLE when start_i=0. A held start therefore never re-triggers a session.
- **Abort:** start_i=0 in REQ, WAIT_LTR, ANSWER or SHOW goes to IDLE on the next edge.
  - dec_arm_o and result flags drop.
  - round_o/score_o freeze at their current values.
  - dec_done_i is ignored outside ANSWER.
- **Arithmetic:** score_o and round_o never exceed ROUNDS (no wrap). The timer is unsigned with width $clog2(max(ANSWER_TIMEOUT, RESULT_HOLD)).

## Timing
- **Reset:** state IDLE; every output 0; registered start_i = 0, so a start_i held high through reset does not start a session.
- **Start latency:** start_i rising edge at edge n → letter_req_o high in cycle n+1. With letter_ready_i already high, dec_arm_o rises at n+3.
- **Verdict latency:** dec_done_i sampled at edge m → result_valid_o and the updated score_o at m+1.
- **Timeout:** dec_arm_o is high for exactly ANSWER_TIMEOUT cycles.
- **Outputs:** all outputs are registered or decoded from registered state only. No combinational path exists from any input to any output.

## Structure
- **Package `morse_pkg`:** state enum `session_state_e`, plus default timing localparams shared with the decoder: DOT/DASH/GAP/CHAR times and the defaults above.
- **Sub-module `morse_tick_timer`:** a reusable load/enable up-counter with a `hit` output at a programmed terminal count. It serves both the ANSWER and SHOW periods; one instance is shared because the two periods never overlap.

## Test plan
- ROUNDS=3, all answers correct (done+correct 5 cycles into ANSWER) → three letter_req_o pulses, score_o=3, round_o=3, session_done_o=1, pass_o=1 with PASS_SCORE=2.
- ANSWER_TIMEOUT=8, no dec_done_i → dec_arm_o high exactly 8 cycles, then timeout_o=1, result_ok_o=0, score_o unchanged.
- dec_done_i=1 with dec_correct_i=1 in the last timeout cycle → result_ok_o=1, timeout_o=0, score_o+1.
- start_i dropped mid-ANSWER in round 2 → IDLE next edge, dec_arm_o=0, round_o=1 frozen; a new rising edge clears round_o/score_o to 0.
- start_i held high after DONE → no new letter_req_o; start low then high → new session.
- rst_i asserted asynchronously during SHOW → all outputs 0 immediately; after release with start_i high, no session starts until start_i toggles.
